// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for inter-stage pipeline buffers:
// stage bundle layout, NOP encoding and stall/flush bus indices.
package pipe_stage_buf_pkg;

  localparam int ALUSEL_W = 3;
  localparam int ALUOP_W  = 8;
  localparam int REG_W    = 32;
  localparam int WD_W     = 5;
  localparam int PC_W     = 32;

  typedef struct packed {
    logic [ALUSEL_W-1:0] alusel;
    logic [ALUOP_W-1:0]  aluop;
    logic [REG_W-1:0]    reg1;
    logic [REG_W-1:0]    reg2;
    logic [WD_W-1:0]     wd;
    logic                wreg;
    logic [PC_W-1:0]     pc;
    logic [REG_W-1:0]    offset;
    logic                jmp;
  } stage_bundle_t;

  localparam int BUNDLE_W = $bits(stage_bundle_t);

  localparam stage_bundle_t NOP_BUNDLE = '0;

  // Bit positions on the core stall/flush buses
  localparam int STALL_IF  = 0;
  localparam int STALL_ID  = 1;
  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;
  localparam int STALL_W   = 5;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  function automatic logic [BUNDLE_W-1:0] pack_bundle(
    input stage_bundle_t b
  );
    return b;
  endfunction

  function automatic logic [1:0] occ_count(
    input logic main_v,
    input logic skid_v
  );
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset,
// used for bubble and other performance counters.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, hold, flush and bubble count.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int                DATA_W = 128,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int                SKID   = 1,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              act;
  logic              push;
  logic              pop;
  buf_state_e        state;

  assign act       = ~hold_i & ~flush_i;
  assign out_valid = main_v_q & act;
  assign out_data  = main_v_q ? main_q : BUBBLE;
  assign occupancy = occ_count(main_v_q, skid_v_q);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign state     = buf_state_e'(occupancy);

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = BUBBLE;
      skid_d   = BUBBLE;
    end else if (!hold_i) begin
      case (state)
        BUF_EMPTY: begin
          if (push) begin
            main_v_d = 1'b1;
            main_d   = in_data;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_v_d = 1'b1;
            skid_d   = in_data;
          end else if (pop) begin
            main_v_d = 1'b0;
            main_d   = BUBBLE;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
            skid_d   = BUBBLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      main_q   <= BUBBLE;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: never depends on out_ready
      assign in_ready = ~skid_v_q & act & ~rst;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_v_q <= 1'b0;
          skid_q   <= BUBBLE;
        end else begin
          skid_v_q <= skid_v_d;
          skid_q   <= skid_d;
        end
      end
    end else begin : g_single
      assign in_ready = (~main_v_q | out_ready) & act & ~rst;
      assign skid_v_q = 1'b0;
      assign skid_q   = BUBBLE;
    end
  endgenerate

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(out_ready & ~main_v_q & act),
    .cnt_o(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus randomized
// traffic checked against a queue-based FIFO model.
module tb_pipe_stage_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hold_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic [1:0] bubble_cnt;

  logic        in_valid0 = 1'b0;
  logic        in_ready0;
  logic [7:0]  in_data0 = 8'h00;
  logic        out_valid0;
  logic        out_ready0 = 1'b0;
  logic [7:0]  out_data0;
  logic [1:0]  occupancy0;
  logic [15:0] bubble_cnt0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic [1:0] mcnt;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W(8), .BUBBLE(8'h00), .SKID(1), .CNT_W(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (hold_i),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_buf #(
    .DATA_W(8), .BUBBLE(8'h00), .SKID(0), .CNT_W(16)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (1'b0),
    .flush_i   (1'b0),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_data   (in_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_data  (out_data0),
    .occupancy (occupancy0),
    .bubble_cnt(bubble_cnt0)
  );

  always @(posedge clk)
    if (!rst)
      assert (!(dut.skid_v_q && !dut.main_v_q))
      else begin
        $display("FAIL invariant: skid_v=1 with main_v=0");
        n_err++;
      end

  task automatic drv(input logic h, input logic f, input logic iv,
                     input logic [7:0] d, input logic ordy);
    @(negedge clk);
    hold_i = h; flush_i = f; in_valid = iv;
    in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hold_i = 0; flush_i = 0; in_valid = 0; out_ready = 0;
    in_valid0 = 0; out_ready0 = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00
        || occupancy !== 2'd0 || bubble_cnt !== 2'd0) begin
      $display("FAIL reset_init: ov=%b ir=%b od=%h occ=%0d bc=%0d want 0 0 00 0 0",
               out_valid, in_ready, out_data, occupancy, bubble_cnt);
      n_err++;
    end
    @(negedge clk); rst = 1'b0;
    drv(0, 0, 1, 8'hA1, 0);
    drv(0, 0, 1, 8'hB2, 0);
    drv(0, 0, 0, 8'h00, 1);
    n_cmp++;
    if (occupancy !== 2'd2) begin
      $display("FAIL reset_prefill: occ=%0d want 2", occupancy);
      n_err++;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00
        || occupancy !== 2'd0 || bubble_cnt !== 2'd0) begin
      $display("FAIL reset_mid: ov=%b ir=%b od=%h occ=%0d bc=%0d want 0 0 00 0 0",
               out_valid, in_ready, out_data, occupancy, bubble_cnt);
      n_err++;
    end
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    do_reset();
    drv(0, 0, 1, vals[0], 1);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL stream_first: ov=%b ir=%b want 0 1", out_valid, in_ready);
      n_err++;
    end
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, i < 2, (i < 2) ? vals[i+1] : 8'h00, 1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        $display("FAIL stream_%0d: ov=%b od=%h want 1 %h",
                 i, out_valid, out_data, vals[i]);
        n_err++;
      end
    end
    drv(0, 0, 0, 8'h00, 1);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      $display("FAIL stream_drain: ov=%b od=%h want 0 00", out_valid, out_data);
      n_err++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drv(0, 0, 1, 8'h0A, 0);
    drv(0, 0, 1, 8'h0B, 0);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL bp_second_ready: ir=%b want 1", in_ready);
      n_err++;
    end
    drv(0, 0, 0, 8'h00, 0);
    n_cmp++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'h0A) begin
      $display("FAIL bp_full: occ=%0d ir=%b od=%h want 2 0 0a",
               occupancy, in_ready, out_data);
      n_err++;
    end
    drv(0, 0, 0, 8'h00, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h0A) begin
      $display("FAIL bp_pop1: ov=%b od=%h want 1 0a", out_valid, out_data);
      n_err++;
    end
    drv(0, 0, 0, 8'h00, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h0B || occupancy !== 2'd1) begin
      $display("FAIL bp_pop2: ov=%b od=%h occ=%0d want 1 0b 1",
               out_valid, out_data, occupancy);
      n_err++;
    end
    drv(0, 0, 0, 8'h00, 1);
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      $display("FAIL bp_empty: ov=%b occ=%0d want 0 0", out_valid, occupancy);
      n_err++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    drv(0, 0, 1, 8'h0A, 0);
    drv(0, 0, 1, 8'h0B, 0);
    drv(1, 1, 1, 8'h0C, 1);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL flush_gate: ir=%b ov=%b want 0 0", in_ready, out_valid);
      n_err++;
    end
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 8'h00, 1);
      n_cmp++;
      if (occupancy !== 2'd0 || out_data !== 8'h00 || out_valid !== 1'b0) begin
        $display("FAIL flush_after_%0d: occ=%0d od=%h ov=%b want 0 00 0",
                 i, occupancy, out_data, out_valid);
        n_err++;
      end
    end
  endtask

  task automatic test_hold();
    logic [1:0] bc0;
    do_reset();
    drv(0, 0, 1, 8'h05, 0);
    drv(1, 0, 1, 8'h66, 1);
    bc0 = bubble_cnt;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drv(1, 0, 1, 8'h66, 1);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h05
          || occupancy !== 2'd1 || bubble_cnt !== bc0) begin
        $display("FAIL hold_%0d: ov=%b ir=%b od=%h occ=%0d bc=%0d want 0 0 05 1 %0d",
                 i, out_valid, in_ready, out_data, occupancy, bubble_cnt, bc0);
        n_err++;
      end
    end
    drv(0, 0, 0, 8'h00, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h05) begin
      $display("FAIL hold_release: ov=%b od=%h want 1 05", out_valid, out_data);
      n_err++;
    end
    drv(0, 0, 0, 8'h00, 0);
    n_cmp++;
    if (occupancy !== 2'd0) begin
      $display("FAIL hold_drain: occ=%0d want 0", occupancy);
      n_err++;
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    do_reset();
    drv(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 8'h00, 1);
      want = (i < 3) ? 2'(i + 1) : 2'd3;
      n_cmp++;
      if (bubble_cnt !== want) begin
        $display("FAIL sat_%0d: bc=%0d want %0d", i, bubble_cnt, want);
        n_err++;
      end
    end
  endtask

  task automatic test_single_entry();
    do_reset();
    @(negedge clk);
    in_valid0 = 1; in_data0 = 8'h44; out_ready0 = 0; #1;
    n_cmp++;
    if (in_ready0 !== 1'b1) begin
      $display("FAIL s0_empty_ready: ir=%b want 1", in_ready0);
      n_err++;
    end
    @(negedge clk);
    in_valid0 = 1; in_data0 = 8'h55; out_ready0 = 0; #1;
    n_cmp++;
    if (in_ready0 !== 1'b0 || occupancy0 !== 2'd1) begin
      $display("FAIL s0_stall: ir=%b occ=%0d want 0 1", in_ready0, occupancy0);
      n_err++;
    end
    out_ready0 = 1; #1;
    n_cmp++;
    if (in_ready0 !== 1'b1 || out_data0 !== 8'h44 || out_valid0 !== 1'b1) begin
      $display("FAIL s0_passthru: ir=%b od=%h ov=%b want 1 44 1",
               in_ready0, out_data0, out_valid0);
      n_err++;
    end
    @(negedge clk);
    in_valid0 = 0; #1;
    n_cmp++;
    if (out_data0 !== 8'h55 || occupancy0 !== 2'd1) begin
      $display("FAIL s0_next: od=%h occ=%0d want 55 1", out_data0, occupancy0);
      n_err++;
    end
    @(negedge clk);
    out_ready0 = 0;
  endtask

  task automatic test_random();
    logic       h, f, iv, ordy;
    logic [7:0] d;
    logic       e_ir, e_ov;
    logic [7:0] e_od;
    int         sz;
    do_reset();
    mq.delete();
    mcnt = 2'd0;
    for (int i = 0; i < 400; i++) begin
      h    = ($urandom % 10) == 0;
      f    = ($urandom % 20) == 0;
      iv   = ($urandom % 10) < 6;
      ordy = ($urandom % 10) < 6;
      d    = 8'($urandom);
      drv(h, f, iv, d, ordy);
      sz   = mq.size();
      e_ir = !h && !f && sz < 2;
      e_ov = !h && !f && sz > 0;
      e_od = (sz > 0) ? mq[0] : 8'h00;
      n_cmp++;
      if (in_ready !== e_ir || out_valid !== e_ov || out_data !== e_od
          || occupancy !== 2'(sz) || bubble_cnt !== mcnt) begin
        $display("FAIL rand_%0d: ir=%b ov=%b od=%h occ=%0d bc=%0d want %b %b %h %0d %0d",
                 i, in_ready, out_valid, out_data, occupancy, bubble_cnt,
                 e_ir, e_ov, e_od, sz, mcnt);
        n_err++;
      end
      if (ordy && sz == 0 && !h && !f && mcnt != 2'd3)
        mcnt = mcnt + 2'd1;
      if (f) begin
        mq.delete();
      end else begin
        if (e_ov && ordy) void'(mq.pop_front());
        if (iv && e_ir) mq.push_back(d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hold();
    test_saturation();
    test_single_entry();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
